// File: rtl/fast_ring_detector.sv
// Ring-arc keypoint detector: three-stage valid/ready pipeline that flags a contiguous arc of
// ring pixels all brighter or all darker than the centre, with polarity and a corner score.
module fast_ring_detector #(
  parameter int PW          = 8,
  parameter int RING        = 8,
  parameter int TAG_W       = 20,
  parameter int FILTER_MODE = 0,
  parameter int CNT_W       = 16
) (
  input  logic                          clk,
  input  logic                          rst,
  input  logic                          in_valid,
  output logic                          in_ready,
  input  logic [PW-1:0]                 center,
  input  logic [RING*PW-1:0]            ring_pixels,
  input  logic [TAG_W-1:0]              in_tag,
  input  logic [PW-1:0]                 cfg_threshold,
  input  logic [$clog2(RING):0]         cfg_arc_len,
  output logic                          out_valid,
  input  logic                          out_ready,
  output logic                          out_keypoint,
  output logic                          out_polarity,
  output logic [PW+$clog2(RING)-1:0]    out_score,
  output logic [TAG_W-1:0]              out_tag,
  input  logic                          cnt_clear,
  output logic [CNT_W-1:0]              keypoint_count
);

  localparam int IW = $clog2(RING);
  localparam int LW = IW + 1;
  localparam int SW = PW + IW;

  function automatic logic [PW-1:0] sat_add(input logic [PW-1:0] a, input logic [PW-1:0] b);
    logic [PW:0] s;
    s = {1'b0, a} + {1'b0, b};
    return s[PW] ? {PW{1'b1}} : s[PW-1:0];
  endfunction

  function automatic logic [LW-1:0] clamp_len(input logic [LW-1:0] l);
    if (l == '0)
      return LW'(1);
    else if (l > LW'(RING))
      return LW'(RING);
    return l;
  endfunction

  // True when some rotation of the ring starts a run of len consecutive set flags.
  function automatic logic arc_find(input logic [RING-1:0] f, input logic [LW-1:0] len);
    logic hit;
    logic run;
    hit = 1'b0;
    for (int i = 0; i < RING; i++) begin
      run = 1'b1;
      for (int j = 0; j < RING; j++)
        if (j < int'(len) && !f[IW'((i + j) % RING)])
          run = 1'b0;
      hit = hit | run;
    end
    return hit;
  endfunction

  // ---------------- handshake control ----------------
  logic r_alive;
  logic r_vld_p1, r_vld_p2, r_vld_p3;
  logic w_ld_p1, w_ld_p2, w_ld_p3, w_acc;

  assign w_ld_p3  = !r_vld_p3 | out_ready;
  assign w_ld_p2  = !r_vld_p2 | w_ld_p3;
  assign w_ld_p1  = !r_vld_p1 | w_ld_p2;
  assign in_ready = r_alive & w_ld_p1;
  assign w_acc    = in_valid & in_ready;

  // ---------------- S1: threshold bounds and per-pixel margins ----------------
  logic [PW-1:0]   w_hi, w_lo;
  logic            w_dark_en;
  logic [RING-1:0] w_bright, w_dark;
  logic [PW-1:0]   w_mb [RING];
  logic [PW-1:0]   w_md [RING];
  logic [PW-1:0]   w_pix;

  assign w_hi      = sat_add(center, cfg_threshold);
  assign w_dark_en = (cfg_threshold <= center);
  assign w_lo      = center - cfg_threshold;

  always_comb begin
    w_bright = '0;
    w_dark   = '0;
    w_pix    = '0;
    for (int k = 0; k < RING; k++) begin
      w_pix       = ring_pixels[k*PW +: PW];
      w_bright[k] = (w_pix > w_hi);
      w_dark[k]   = w_dark_en && (w_pix < w_lo);
      w_mb[k]     = w_bright[k] ? (w_pix - w_hi) : '0;
      w_md[k]     = w_dark[k] ? (w_lo - w_pix) : '0;
    end
  end

  logic [RING-1:0]  r_b_p1, r_d_p1;
  logic [PW-1:0]    r_mb_p1 [RING];
  logic [PW-1:0]    r_md_p1 [RING];
  logic [LW-1:0]    r_len_p1;
  logic [TAG_W-1:0] r_tag_p1;

  always_ff @(posedge clk) begin
    if (w_acc) begin
      r_b_p1   <= w_bright;
      r_d_p1   <= w_dark;
      r_len_p1 <= clamp_len(cfg_arc_len);
      r_tag_p1 <= in_tag;
      for (int k = 0; k < RING; k++) begin
        r_mb_p1[k] <= w_mb[k];
        r_md_p1[k] <= w_md[k];
      end
    end
  end

  // ---------------- S2: arc search and margin sums ----------------
  logic [SW-1:0] w_sb, w_sd;

  always_comb begin
    w_sb = '0;
    w_sd = '0;
    for (int k = 0; k < RING; k++) begin
      w_sb = w_sb + SW'(r_mb_p1[k]);
      w_sd = w_sd + SW'(r_md_p1[k]);
    end
  end

  logic             r_ab_p2, r_ad_p2;
  logic [SW-1:0]    r_sb_p2, r_sd_p2;
  logic [TAG_W-1:0] r_tag_p2;

  always_ff @(posedge clk) begin
    if (w_ld_p2 && r_vld_p1) begin
      r_ab_p2  <= arc_find(r_b_p1, r_len_p1);
      r_ad_p2  <= arc_find(r_d_p1, r_len_p1);
      r_sb_p2  <= w_sb;
      r_sd_p2  <= w_sd;
      r_tag_p2 <= r_tag_p1;
    end
  end

  // ---------------- S3: polarity resolution and output register ----------------
  logic          w_kp, w_pol;
  logic [SW-1:0] w_score;

  assign w_kp    = r_ab_p2 | r_ad_p2;
  assign w_pol   = (r_ab_p2 & r_ad_p2) ? (r_sb_p2 >= r_sd_p2) : r_ab_p2;
  assign w_score = !w_kp ? '0 : (w_pol ? r_sb_p2 : r_sd_p2);

  logic             r_kp_p3, r_pol_p3;
  logic [SW-1:0]    r_score_p3;
  logic [TAG_W-1:0] r_tag_p3;
  logic [CNT_W-1:0] r_cnt;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_alive    <= 1'b0;
      r_vld_p1   <= 1'b0;
      r_vld_p2   <= 1'b0;
      r_vld_p3   <= 1'b0;
      r_kp_p3    <= 1'b0;
      r_pol_p3   <= 1'b0;
      r_score_p3 <= '0;
      r_tag_p3   <= '0;
    end else begin
      r_alive <= 1'b1;
      if (w_ld_p1)
        r_vld_p1 <= w_acc;
      if (w_ld_p2)
        r_vld_p2 <= r_vld_p1;
      // Filtered non-keypoints vanish here instead of occupying an output slot.
      if (w_ld_p3)
        r_vld_p3 <= r_vld_p2 & ((FILTER_MODE == 0) | w_kp);
      if (w_ld_p3 && r_vld_p2) begin
        r_kp_p3    <= w_kp;
        r_pol_p3   <= w_pol;
        r_score_p3 <= w_score;
        r_tag_p3   <= r_tag_p2;
      end
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst)
      r_cnt <= '0;
    else if (cnt_clear)
      r_cnt <= '0;
    else if (r_vld_p3 && out_ready && r_kp_p3 && (r_cnt != {CNT_W{1'b1}}))
      r_cnt <= r_cnt + 1'b1;
  end

  assign out_valid      = r_vld_p3;
  assign out_keypoint   = r_kp_p3;
  assign out_polarity   = r_pol_p3;
  assign out_score      = r_score_p3;
  assign out_tag        = r_tag_p3;
  assign keypoint_count = r_cnt;

endmodule

// File: tb/tb_fast_ring_detector.sv
// Directed bench for fast_ring_detector: table of single-beat vectors plus stall, config,
// filter, counter and reset sequences.
module tb_fast_ring_detector;
  localparam int PW    = 8;
  localparam int RING  = 8;
  localparam int TAG_W = 20;
  localparam int LW    = 4;
  localparam int SW    = 11;
  localparam int CNT_W = 4;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic               rst, in_valid, out_ready, cnt_clear;
  logic [PW-1:0]      center, cfg_threshold;
  logic [RING*PW-1:0] ring_pixels;
  logic [TAG_W-1:0]   in_tag;
  logic [LW-1:0]      cfg_arc_len;

  logic               in_ready, out_valid, out_keypoint, out_polarity;
  logic [SW-1:0]      out_score;
  logic [TAG_W-1:0]   out_tag;
  logic [CNT_W-1:0]   keypoint_count;

  logic               in_ready_f, out_valid_f, out_keypoint_f, out_polarity_f;
  logic [SW-1:0]      out_score_f;
  logic [TAG_W-1:0]   out_tag_f;
  logic [CNT_W-1:0]   keypoint_count_f;

  fast_ring_detector #(.PW(PW), .RING(RING), .TAG_W(TAG_W), .FILTER_MODE(0), .CNT_W(CNT_W)) u_dut (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready), .center(center),
    .ring_pixels(ring_pixels), .in_tag(in_tag), .cfg_threshold(cfg_threshold),
    .cfg_arc_len(cfg_arc_len), .out_valid(out_valid), .out_ready(out_ready),
    .out_keypoint(out_keypoint), .out_polarity(out_polarity), .out_score(out_score),
    .out_tag(out_tag), .cnt_clear(cnt_clear), .keypoint_count(keypoint_count));

  fast_ring_detector #(.PW(PW), .RING(RING), .TAG_W(TAG_W), .FILTER_MODE(1), .CNT_W(CNT_W)) u_dut_f (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready_f), .center(center),
    .ring_pixels(ring_pixels), .in_tag(in_tag), .cfg_threshold(cfg_threshold),
    .cfg_arc_len(cfg_arc_len), .out_valid(out_valid_f), .out_ready(out_ready),
    .out_keypoint(out_keypoint_f), .out_polarity(out_polarity_f), .out_score(out_score_f),
    .out_tag(out_tag_f), .cnt_clear(cnt_clear), .keypoint_count(keypoint_count_f));

  typedef struct {
    logic [PW-1:0]      c;
    logic [RING*PW-1:0] ring;
    logic [PW-1:0]      thr;
    logic [LW-1:0]      len;
    logic               ekp;
    logic               epol;
    logic [SW-1:0]      escore;
  } vec_t;

  int n_cmp = 0;
  int n_bad = 0;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0d, expected %0d", name, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  function automatic logic [63:0] r8(input int p0, input int p1, input int p2, input int p3,
                                     input int p4, input int p5, input int p6, input int p7);
    return {8'(p7), 8'(p6), 8'(p5), 8'(p4), 8'(p3), 8'(p2), 8'(p1), 8'(p0)};
  endfunction

  function automatic vec_t mkv(input int c, input logic [63:0] ring, input int thr, input int len,
                               input int kp, input int pol, input int score);
    vec_t v;
    v.c = PW'(c); v.ring = ring; v.thr = PW'(thr); v.len = LW'(len);
    v.ekp = kp[0]; v.epol = pol[0]; v.escore = SW'(score);
    return v;
  endfunction

  task automatic set_beat(input vec_t v, input int tag);
    center        = v.c;
    ring_pixels   = v.ring;
    cfg_threshold = v.thr;
    cfg_arc_len   = v.len;
    in_tag        = TAG_W'(tag);
  endtask

  vec_t vt [13];
  vec_t v_kp, v_nk;

  initial begin
    int sent, recv, cyc, nf, dup;
    logic saw_stall, hold_pending, bad_flag;
    logic [TAG_W-1:0] prev_tag;

    vt[0]  = mkv(100, r8(120,120,120,120,100,100,100,100), 7, 4, 1, 1, 52);
    vt[1]  = mkv(100, r8(50,50,100,100,100,100,50,50), 7, 4, 1, 0, 172);
    vt[2]  = mkv(100, r8(50,50,100,100,100,100,50,50), 7, 5, 0, 0, 0);
    vt[3]  = mkv(250, r8(255,255,255,255,255,255,255,255), 10, 4, 0, 0, 0);
    vt[4]  = mkv(5, r8(0,0,0,0,0,0,0,0), 10, 4, 0, 0, 0);
    vt[5]  = mkv(100, r8(100,100,100,108,100,100,100,100), 7, 0, 1, 1, 1);
    vt[6]  = mkv(100, r8(110,110,110,110,110,110,110,110), 0, 15, 1, 1, 80);
    vt[7]  = mkv(100, r8(120,120,120,120,70,70,70,70), 10, 4, 1, 0, 80);
    vt[8]  = mkv(100, r8(130,130,130,130,70,70,70,70), 10, 4, 1, 1, 80);
    vt[9]  = mkv(100, r8(150,150,150,150,80,80,80,80), 10, 4, 1, 1, 160);
    vt[10] = mkv(100, r8(120,120,100,120,120,100,100,100), 7, 3, 0, 0, 0);
    vt[11] = mkv(100, r8(107,107,107,107,107,107,107,107), 7, 1, 0, 0, 0);
    vt[12] = mkv(10, r8(0,0,0,0,0,0,0,0), 9, 8, 1, 0, 8);
    v_kp = vt[0];
    v_nk = mkv(100, r8(100,100,100,100,100,100,100,100), 7, 4, 0, 0, 0);

    rst = 1'b1; in_valid = 1'b0; out_ready = 1'b1; cnt_clear = 1'b0;
    set_beat(v_nk, 0);
    tick(); tick();
    chk("rst_out_valid", out_valid, 0);
    chk("rst_out_keypoint", out_keypoint, 0);
    chk("rst_out_score", out_score, 0);
    chk("rst_out_tag", out_tag, 0);
    chk("rst_count", keypoint_count, 0);
    rst = 1'b0;
    tick();
    chk("in_ready_after_rst", in_ready, 1);

    // Table: one beat at a time, latency and result checks.
    for (int i = 0; i < 13; i++) begin
      set_beat(vt[i], 16 + i);
      in_valid = 1'b1;
      tick();
      in_valid = 1'b0;
      chk($sformatf("v%0d_lat1", i), out_valid, 0);
      tick();
      chk($sformatf("v%0d_lat2", i), out_valid, 0);
      tick();
      chk($sformatf("v%0d_valid", i), out_valid, 1);
      chk($sformatf("v%0d_kp", i), out_keypoint, vt[i].ekp);
      chk($sformatf("v%0d_pol", i), out_polarity, vt[i].epol);
      chk($sformatf("v%0d_score", i), out_score, vt[i].escore);
      chk($sformatf("v%0d_tag", i), out_tag, 16 + i);
      tick();
    end

    // Threshold change right after acceptance must not touch the in-flight beat.
    set_beat(v_kp, 'h777);
    in_valid = 1'b1;
    tick();
    in_valid = 1'b0;
    cfg_threshold = 8'd50;
    tick(); tick();
    chk("cfg_valid", out_valid, 1);
    chk("cfg_kp", out_keypoint, 1);
    chk("cfg_score", out_score, 52);
    tick();

    // Backpressure with out_ready pattern 1,0,0.
    sent = 0; recv = 0; cyc = 0; saw_stall = 1'b0; hold_pending = 1'b0; prev_tag = '0;
    while (recv < 10 && cyc < 300) begin
      out_ready = (cyc % 3 == 0);
      in_valid  = (sent < 10);
      if (sent < 10) set_beat(v_kp, 100 + sent);
      #1;
      if (hold_pending) begin
        chk("bp_hold_valid", out_valid, 1);
        chk("bp_hold_tag", out_tag, prev_tag);
      end
      if (!in_ready) saw_stall = 1'b1;
      if (in_valid && in_ready) sent++;
      if (out_valid && out_ready) begin
        chk("bp_tag", out_tag, 100 + recv);
        recv++;
      end
      hold_pending = out_valid && !out_ready;
      prev_tag = out_tag;
      cyc++;
      tick();
    end
    chk("bp_all_received", recv, 10);
    chk("bp_in_ready_dropped", saw_stall, 1);
    out_ready = 1'b1; in_valid = 1'b0;
    dup = 0;
    repeat (5) begin
      if (out_valid) dup++;
      tick();
    end
    chk("bp_no_duplicate", dup, 0);

    // Filtered instance: alternating keypoint / non-keypoint beats.
    cnt_clear = 1'b1;
    tick();
    cnt_clear = 1'b0;
    nf = 0;
    for (int c = 0; c < 14; c++) begin
      if (c < 6) begin
        set_beat((c % 2 == 0) ? v_kp : v_nk, 200 + c);
        in_valid = 1'b1;
        chk("filt_in_ready", in_ready_f, 1);
      end else begin
        in_valid = 1'b0;
      end
      if (out_valid_f) begin
        chk("filt_tag", out_tag_f, 200 + 2 * nf);
        chk("filt_kp", out_keypoint_f, 1);
        chk("filt_pol", out_polarity_f, 1);
        chk("filt_score", out_score_f, 52);
        nf++;
      end
      tick();
    end
    chk("filt_emitted", nf, 3);
    chk("filt_count", keypoint_count_f, 3);

    // Saturating counter.
    cnt_clear = 1'b1;
    tick();
    cnt_clear = 1'b0;
    chk("cnt_cleared", keypoint_count, 0);
    for (int i = 0; i < 20; i++) begin
      set_beat(v_kp, 300 + i);
      in_valid = 1'b1;
      tick();
      if (i == 6) chk("cnt_midway", keypoint_count, 4);
    end
    in_valid = 1'b0;
    repeat (5) tick();
    chk("cnt_saturated", keypoint_count, 15);

    set_beat(v_kp, 400);
    in_valid = 1'b1;
    tick();
    in_valid = 1'b0;
    tick(); tick();
    chk("cnt_clr_valid", out_valid, 1);
    cnt_clear = 1'b1;
    tick();
    cnt_clear = 1'b0;
    chk("cnt_clear_wins", keypoint_count, 0);
    set_beat(v_kp, 401);
    in_valid = 1'b1;
    tick();
    in_valid = 1'b0;
    repeat (4) tick();
    chk("cnt_after_clear", keypoint_count, 1);

    // Reset in the middle of a transfer discards the in-flight beat.
    set_beat(v_kp, 500);
    in_valid = 1'b1;
    tick();
    in_valid = 1'b0;
    rst = 1'b1;
    #1;
    chk("midrst_out_valid", out_valid, 0);
    tick();
    rst = 1'b0;
    bad_flag = 1'b0;
    repeat (5) begin
      if (out_valid) bad_flag = 1'b1;
      tick();
    end
    chk("midrst_no_output", bad_flag, 0);
    chk("midrst_count", keypoint_count, 0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
